// File: rtl/asym_dpram_stream.sv
// Asymmetric dual-port RAM: narrow R/W CPU port A, wide read-only burst-streaming port B
// with credit-limited prefetch into a small first-word-fall-through output FIFO.
module asym_dpram_stream #(
    parameter int  A_WIDTH    = 8,
    parameter int  A_DEPTH    = 4096,
    parameter int  RATIO      = 2,
    parameter int  WRITE_MODE = 0,
    parameter int  OUT_REG    = 1,
    localparam int A_AW       = $clog2(A_DEPTH),
    localparam int B_AW       = A_AW - $clog2(RATIO),
    localparam int B_WIDTH    = A_WIDTH * RATIO
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               ena_i,
    input  logic               wea_i,
    input  logic [A_AW-1:0]    addra_i,
    input  logic [A_WIDTH-1:0] dia_i,
    output logic [A_WIDTH-1:0] doa_o,
    input  logic               start_i,
    input  logic [B_AW-1:0]    base_i,
    input  logic [B_AW:0]      len_i,
    input  logic               abort_i,
    output logic [B_WIDTH-1:0] dob_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic               busy_o,
    output logic               done_o
);
    localparam int FIFO_DEPTH = 2 + OUT_REG;
    localparam int Q_DEPTH    = FIFO_DEPTH - 1;
    localparam int QW         = $clog2(Q_DEPTH + 1);
    localparam int QIW        = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
    localparam int LW         = (RATIO > 1) ? $clog2(RATIO) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

    logic [B_WIDTH-1:0] r_mem [1 << B_AW];

    logic [B_AW-1:0]    w_a_word;
    logic [LW-1:0]      w_a_lane;
    logic [A_WIDTH-1:0] w_a_old;
    logic [A_WIDTH-1:0] r_doa;

    assign w_a_word = B_AW'(addra_i >> $clog2(RATIO));
    assign w_a_lane = LW'(addra_i % RATIO);
    assign w_a_old  = r_mem[w_a_word][w_a_lane*A_WIDTH +: A_WIDTH];
    assign doa_o    = r_doa;

    always_ff @(posedge clk_i) begin
        if (ena_i && wea_i) r_mem[w_a_word][w_a_lane*A_WIDTH +: A_WIDTH] <= dia_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_doa <= '0;
        end else if (ena_i) begin
            if (!wea_i || WRITE_MODE == 1) r_doa <= w_a_old;
            else if (WRITE_MODE == 2)      r_doa <= dia_i;
        end
    end

    state_t             r_state, w_state_nxt;
    logic [B_AW-1:0]    r_addr;
    logic [B_AW:0]      r_remain, r_xfer_left;
    logic               r_done;
    logic [OUT_REG:0]   r_vld_pipe;
    logic [B_WIDTH-1:0] r_rd_pipe [OUT_REG+1];
    logic [B_WIDTH-1:0] r_q [Q_DEPTH];
    logic [QW-1:0]      r_qcnt;
    logic [B_WIDTH-1:0] r_dob;
    logic               r_vld;

    logic               w_pop, w_push, w_take, w_qpop, w_qpush, w_room;
    logic               w_issue, w_accept, w_zero_start, w_last_xfer, w_done_nxt, w_can_start;
    logic [2:0]         w_inflt, w_cnt;
    logic [QIW-1:0]     w_qwidx;
    logic [B_WIDTH-1:0] w_pdata;

    assign w_pop   = r_vld && ready_i;
    assign w_push  = r_vld_pipe[OUT_REG];
    assign w_pdata = r_rd_pipe[OUT_REG];
    assign w_take  = !r_vld || w_pop;
    assign w_qpop  = w_take && (r_qcnt != '0);
    assign w_qpush = w_push && !(w_take && (r_qcnt == '0));
    assign w_qwidx = QIW'(r_qcnt - QW'(w_qpop));
    assign dob_o   = r_dob;
    assign valid_o = r_vld;
    assign done_o  = r_done;

    // Credit counts words already in the pipe plus FIFO occupancy, net of this cycle's pop,
    // so a steady-state stream with ready held high never bubbles and never overflows.
    always_comb begin
        w_inflt = '0;
        for (int i = 0; i <= OUT_REG; i++) w_inflt = w_inflt + 3'(r_vld_pipe[i]);
        w_cnt  = 3'(r_vld) + 3'(r_qcnt);
        w_room = (w_inflt + w_cnt - 3'(w_pop)) < 3'(FIFO_DEPTH);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (abort_i) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (w_accept) w_state_nxt = ST_RUN;
                ST_RUN:   if (w_issue && r_remain == 1) w_state_nxt = ST_DRAIN;
                ST_DRAIN: if (w_last_xfer) w_state_nxt = w_accept ? ST_RUN : ST_IDLE;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o       = (r_state != ST_IDLE);
        w_last_xfer  = (r_state == ST_DRAIN) && w_pop && (r_xfer_left == 1);
        w_can_start  = start_i && !abort_i && ((r_state == ST_IDLE) || w_last_xfer);
        w_accept     = w_can_start && (len_i != '0);
        w_zero_start = w_can_start && (len_i == '0);
        w_issue      = (r_state == ST_RUN) && !abort_i && (r_remain != '0) && w_room;
        w_done_nxt   = !abort_i && (w_last_xfer || w_zero_start);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_addr      <= '0;
            r_remain    <= '0;
            r_xfer_left <= '0;
            r_done      <= 1'b0;
            r_vld_pipe  <= '0;
        end else begin
            r_done <= w_done_nxt;
            if (w_accept) begin
                r_addr      <= base_i;
                r_remain    <= len_i;
                r_xfer_left <= len_i;
            end else begin
                if (w_issue) begin
                    r_addr   <= r_addr + 1'b1;
                    r_remain <= r_remain - 1'b1;
                end
                if (w_pop) r_xfer_left <= r_xfer_left - 1'b1;
            end
            if (abort_i) begin
                r_vld_pipe <= '0;
            end else begin
                r_vld_pipe[0] <= w_issue;
                for (int i = 1; i <= OUT_REG; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
            end
        end
    end

    // Nonblocking read of r_mem returns the pre-write word when port A hits the same word.
    always_ff @(posedge clk_i) begin
        if (w_issue) r_rd_pipe[0] <= r_mem[r_addr];
        for (int i = 1; i <= OUT_REG; i++) r_rd_pipe[i] <= r_rd_pipe[i-1];
        if (w_qpop) begin
            for (int i = 0; i < Q_DEPTH - 1; i++) r_q[i] <= r_q[i+1];
        end
        if (w_qpush) r_q[w_qwidx] <= w_pdata;
    end

    // Output register is the FIFO head; it keeps its last word when nothing is pending.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_dob  <= '0;
            r_vld  <= 1'b0;
            r_qcnt <= '0;
        end else if (abort_i) begin
            r_vld  <= 1'b0;
            r_qcnt <= '0;
        end else begin
            if (w_take) begin
                if (r_qcnt != '0) begin
                    r_dob <= r_q[0];
                    r_vld <= 1'b1;
                end else if (w_push) begin
                    r_dob <= w_pdata;
                    r_vld <= 1'b1;
                end else begin
                    r_vld <= 1'b0;
                end
            end
            r_qcnt <= r_qcnt + QW'(w_qpush) - QW'(w_qpop);
        end
    end
endmodule

// File: tb/tb_asym_dpram_stream.sv
// Directed bench for asym_dpram_stream: port A modes, burst latency, wrap, backpressure,
// abort/reset, empty burst and port A/B collision, against a shadow narrow memory.
module tb_asym_dpram_stream;
    localparam int OUT_REG = 1;

    logic        clk_i = 1'b0, rst_n_i = 1'b1, ena_i = 1'b0, wea_i = 1'b0;
    logic [11:0] addra_i = '0;
    logic [7:0]  dia_i = '0, doa_o, doa_m1, doa_m2;
    logic        start_i = 1'b0, abort_i = 1'b0, ready_i = 1'b0;
    logic [10:0] base_i = '0;
    logic [11:0] len_i = '0;
    logic [15:0] dob_o;
    logic        valid_o, busy_o, done_o;
    logic [15:0] dob_x [2];
    logic        val_x [2], busy_x [2], done_x [2];
    logic [7:0]  nar [4096];
    int          checks = 0, errs = 0, bc;

    always #5 clk_i = ~clk_i;

    asym_dpram_stream #(.WRITE_MODE(0), .OUT_REG(OUT_REG)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .ena_i(ena_i), .wea_i(wea_i), .addra_i(addra_i),
        .dia_i(dia_i), .doa_o(doa_o), .start_i(start_i), .base_i(base_i), .len_i(len_i),
        .abort_i(abort_i), .dob_o(dob_o), .valid_o(valid_o), .ready_i(ready_i),
        .busy_o(busy_o), .done_o(done_o));

    asym_dpram_stream #(.WRITE_MODE(1), .OUT_REG(OUT_REG)) dut_m1 (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .ena_i(ena_i), .wea_i(wea_i), .addra_i(addra_i),
        .dia_i(dia_i), .doa_o(doa_m1), .start_i(start_i), .base_i(base_i), .len_i(len_i),
        .abort_i(abort_i), .dob_o(dob_x[0]), .valid_o(val_x[0]), .ready_i(ready_i),
        .busy_o(busy_x[0]), .done_o(done_x[0]));

    asym_dpram_stream #(.WRITE_MODE(2), .OUT_REG(OUT_REG)) dut_m2 (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .ena_i(ena_i), .wea_i(wea_i), .addra_i(addra_i),
        .dia_i(dia_i), .doa_o(doa_m2), .start_i(start_i), .base_i(base_i), .len_i(len_i),
        .abort_i(abort_i), .dob_o(dob_x[1]), .valid_o(val_x[1]), .ready_i(ready_i),
        .busy_o(busy_x[1]), .done_o(done_x[1]));

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        ena_i = 1'b1; wea_i = 1'b1; addra_i = 12'(a); dia_i = d;
        step();
        ena_i = 1'b0; wea_i = 1'b0;
        nar[a] = d;
    endtask

    function automatic logic [15:0] exp_word(input int w);
        logic [10:0] ww;
        ww = 11'(w);
        return {nar[{ww, 1'b1}], nar[{ww, 1'b0}]};
    endfunction

    // Busy spans the start edge through the edge of the final handshake: len + 2 + OUT_REG samples.
    task automatic run_burst(input int base, input int len, input bit rnd, output int busy_cyc);
        int idx = 0, cyc = 0, dones = 0, gaps = 0;
        bit stalled = 1'b0;
        logic [15:0] prev = '0;
        busy_cyc = 0;
        base_i = 11'(base); len_i = 12'(len); ready_i = 1'b1; start_i = 1'b1;
        step();
        start_i = 1'b0;
        while (cyc < 4000) begin
            cyc++;
            if (done_o) dones++;
            if (!busy_o) break;
            busy_cyc++;
            if (stalled) chk("stall_hold", {15'd0, valid_o, dob_o}, {15'd0, 1'b1, prev});
            if (!rnd && idx > 0 && idx < len && !valid_o) gaps++;
            ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            stalled = 1'b0;
            if (valid_o) begin
                if (ready_i) begin
                    chk("burst_data", dob_o, exp_word(base + idx));
                    idx++;
                end else begin
                    stalled = 1'b1;
                    prev = dob_o;
                end
            end
            step();
        end
        ready_i = 1'b1;
        chk("burst_timeout", cyc < 4000, 1);
        chk("burst_count", idx, len);
        chk("burst_done", dones, 1);
        if (!rnd) chk("burst_gaps", gaps, 0);
        step();
        chk("done_pulse", done_o, 0);
    endtask

    initial begin
        #1 rst_n_i = 1'b0;
        step(); step();
        chk("rst_doa", doa_o, 0);
        chk("rst_dob", dob_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        rst_n_i = 1'b1;
        step();

        // Port A write then read back, one-cycle latency
        for (int i = 0; i < 256; i++) wr(i, 8'(i));
        for (int i = 0; i < 256; i++) begin
            ena_i = 1'b1; addra_i = 12'(i);
            step();
            chk("a_read", doa_o, i);
        end
        wr(5, 8'hA5);
        chk("wm0_hold", doa_o, 8'hFF);
        chk("wm1_old", doa_m1, 8'h05);
        chk("wm2_new", doa_m2, 8'hA5);
        addra_i = 12'd6;
        step();
        chk("ena0_hold", doa_m2, 8'hA5);
        ena_i = 1'b1; addra_i = 12'd5;
        step();
        ena_i = 1'b0;
        chk("a_reread", doa_o, 8'hA5);

        // Single-word burst: latency, packing, done
        wr(12'h010, 8'h34);
        wr(12'h011, 8'h12);
        ready_i = 1'b1; base_i = 11'h008; len_i = 12'd1; start_i = 1'b1;
        step();
        start_i = 1'b0;
        chk("t2_busy", busy_o, 1);
        for (int c = 0; c < 2 + OUT_REG; c++) begin
            chk("t2_lat", valid_o, 0);
            step();
        end
        chk("t2_valid", valid_o, 1);
        chk("t2_dob", dob_o, 16'h1234);
        chk("t2_nodone", done_o, 0);
        step();
        chk("t2_done", done_o, 1);
        chk("t2_idle", busy_o, 0);
        chk("t2_vlow", valid_o, 0);
        chk("t2_dobhold", dob_o, 16'h1234);
        step();
        chk("t2_donelow", done_o, 0);

        // Wrap across the top of the wide address space
        for (int i = 0; i < 4; i++) wr(12'hFFC + i, 8'hC0 + 8'(i));
        run_burst(11'h7FE, 4, 1'b0, bc);
        chk("t3_busy_cyc", bc, 4 + 2 + OUT_REG);

        // Long burst with random backpressure
        run_burst(11'h020, 64, 1'b1, bc);

        // Abort beats a simultaneous start; no done afterwards
        ready_i = 1'b0; base_i = 11'h020; len_i = 12'd64; start_i = 1'b1;
        step();
        start_i = 1'b0;
        repeat (5) step();
        chk("ab_prefill", valid_o, 1);
        abort_i = 1'b1; start_i = 1'b1; len_i = 12'd4;
        step();
        abort_i = 1'b0; start_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("ab_valid", valid_o, 0);
            chk("ab_busy", busy_o, 0);
            chk("ab_done", done_o, 0);
            step();
        end
        run_burst(11'h008, 1, 1'b0, bc);

        // Reset mid-burst
        ready_i = 1'b1; base_i = 11'h020; len_i = 12'd64; start_i = 1'b1;
        step();
        start_i = 1'b0;
        repeat (4) step();
        rst_n_i = 1'b0;
        #1;
        chk("rs_valid", valid_o, 0);
        chk("rs_busy", busy_o, 0);
        step();
        chk("rs_done", done_o, 0);
        rst_n_i = 1'b1;
        step();
        run_burst(11'h020, 4, 1'b0, bc);

        // Empty burst
        len_i = 12'd0; start_i = 1'b1;
        step();
        start_i = 1'b0;
        chk("len0_done", done_o, 1);
        chk("len0_busy", busy_o, 0);
        chk("len0_valid", valid_o, 0);
        step();
        chk("len0_donelow", done_o, 0);

        // Port A write to the word port B reads on the same edge
        ready_i = 1'b1; base_i = 11'h008; len_i = 12'd1; start_i = 1'b1;
        step();
        start_i = 1'b0;
        ena_i = 1'b1; wea_i = 1'b1; addra_i = 12'h010; dia_i = 8'hAA;
        step();
        ena_i = 1'b0; wea_i = 1'b0;
        nar[12'h010] = 8'hAA;
        repeat (1 + OUT_REG) step();
        chk("col_valid", valid_o, 1);
        chk("col_old", dob_o, 16'h1234);
        step();
        chk("col_done", done_o, 1);
        run_burst(11'h008, 1, 1'b0, bc);
        chk("col_new", dob_o, 16'h12AA);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
